// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and any downstream
// consumer of its key events.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // Seven-segment word: prefix byte (F0 wins over E0) followed by the scan code.
  function automatic logic [15:0] evtToHex(input ps2_evt_t evt);
    logic [7:0] prefix;
    prefix = 8'h00;
    if (evt.brk)      prefix = PS2_BRK;
    else if (evt.ext) prefix = PS2_EXT;
    return {prefix, evt.code};
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead synchronous FIFO for key events; a push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  ps2_evt_t                 data_i,
  input  logic                     pop_i,
  output ps2_evt_t                 data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  ps2_evt_t        mem_q [DEPTH];
  logic [AW-1:0]   rdPtr_q;
  logic [AW-1:0]   wrPtr_q;
  logic [AW:0]     count_q;
  logic            doPush;
  logic            doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign data_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      if (doPush && !doPop)      count_q <= count_q + 1'b1;
      else if (doPop && !doPush) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise and filter the lines, decode 11-bit frames,
// fold E0/F0 prefixes into key events and queue them behind a valid/ready port.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          computerClk,
  input  logic                          rst,
  input  logic                          ps2_kbclk,
  input  logic                          ps2_kbdat,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_brk,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic [15:0]                   hexo,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          overflow
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clkSync_q;
  logic [1:0]    datSync_q;
  logic          filtClk_q;
  logic [FW-1:0] filtCnt_q;
  logic          strobe_q;
  logic          datS;

  ps2_state_e    state_q;
  logic [2:0]    bitCnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] toCnt_q;
  logic          byteOk_q;
  logic          errParity_q;
  logic          errFrame_q;

  logic          extPend_q;
  logic          brkPend_q;
  logic [15:0]   hexo_q;
  logic          overflow_q;

  ps2_evt_t      pushEvt_d;
  ps2_evt_t      headEvt;
  logic          pushReq;
  logic          popReq;
  logic          fifoFull;
  logic          fifoEmpty;

  assign datS = datSync_q[1];

  // The filtered clock only moves after FILTER_LEN agreeing samples; strobe marks its falling edge.
  always_ff @(posedge computerClk) begin
    if (rst) begin
      clkSync_q <= 2'b11;
      datSync_q <= 2'b11;
      filtClk_q <= 1'b1;
      filtCnt_q <= '0;
      strobe_q  <= 1'b0;
    end else begin
      clkSync_q <= {clkSync_q[0], ps2_kbclk};
      datSync_q <= {datSync_q[0], ps2_kbdat};
      strobe_q  <= 1'b0;
      if (clkSync_q[1] == filtClk_q) begin
        filtCnt_q <= '0;
      end else if (filtCnt_q == FW'(FILTER_LEN - 1)) begin
        filtCnt_q <= '0;
        filtClk_q <= clkSync_q[1];
        strobe_q  <= filtClk_q;
      end else begin
        filtCnt_q <= filtCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge computerClk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      toCnt_q     <= '0;
      byteOk_q    <= 1'b0;
      errParity_q <= 1'b0;
      errFrame_q  <= 1'b0;
    end else begin
      byteOk_q    <= 1'b0;
      errParity_q <= 1'b0;
      errFrame_q  <= 1'b0;
      if (strobe_q) begin
        toCnt_q <= '0;
        case (state_q)
          ST_IDLE: begin
            if (!datS) begin
              state_q  <= ST_DATA;
              bitCnt_q <= '0;
            end
          end
          ST_DATA: begin
            shift_q  <= {datS, shift_q[7:1]};
            bitCnt_q <= bitCnt_q + 1'b1;
            if (bitCnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_q <= datS;
            state_q  <= ST_STOP;
          end
          ST_STOP: begin
            // A bad stop bit masks any parity verdict.
            if (!datS)                      errFrame_q  <= 1'b1;
            else if (^{shift_q, parity_q})  byteOk_q    <= 1'b1;
            else                            errParity_q <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q == ST_IDLE) begin
        toCnt_q <= '0;
      end else if (toCnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        errFrame_q <= 1'b1;
        state_q    <= ST_IDLE;
        shift_q    <= '0;
        toCnt_q    <= '0;
      end else begin
        toCnt_q <= toCnt_q + 1'b1;
      end
    end
  end

  assign pushReq   = byteOk_q && (shift_q != PS2_EXT) && (shift_q != PS2_BRK);
  assign pushEvt_d = '{ext: extPend_q, brk: brkPend_q, code: shift_q};
  assign popReq    = evt_valid && evt_ready;

  // Prefix bytes only arm flags; any completed key or receive error disarms them.
  always_ff @(posedge computerClk) begin
    if (rst) begin
      extPend_q  <= 1'b0;
      brkPend_q  <= 1'b0;
      hexo_q     <= 16'h0000;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= pushReq && fifoFull && !popReq;
      if (errParity_q) begin
        extPend_q <= 1'b0;
        brkPend_q <= 1'b0;
        hexo_q    <= 16'hFFFF;
      end else if (errFrame_q) begin
        extPend_q <= 1'b0;
        brkPend_q <= 1'b0;
      end else if (byteOk_q) begin
        if (shift_q == PS2_EXT) begin
          extPend_q <= 1'b1;
        end else if (shift_q == PS2_BRK) begin
          brkPend_q <= 1'b1;
        end else begin
          hexo_q    <= evtToHex(pushEvt_d);
          extPend_q <= 1'b0;
          brkPend_q <= 1'b0;
        end
      end
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (computerClk),
    .rst_i   (rst),
    .push_i  (pushReq),
    .data_i  (pushEvt_d),
    .pop_i   (evt_ready),
    .data_o  (headEvt),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (evt_count)
  );

  assign evt_valid  = !fifoEmpty;
  assign evt_code   = headEvt.code;
  assign evt_ext    = headEvt.ext;
  assign evt_brk    = headEvt.brk;
  assign hexo       = hexo_q;
  assign err_parity = errParity_q;
  assign err_frame  = errFrame_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

Parametrised PS/2 keyboard receiver, successor to the existing negedge-clocked decoder. Runs entirely in the `computerClk` domain. It synchronises and glitch-filters the keyboard lines, decodes 11-bit frames with odd-parity and stop checking plus an inactivity timeout, and folds E0/F0 prefixes into typed key events. Events are buffered in a FIFO behind a valid/ready handshake. A legacy 16-bit `hexo` display word is kept for the seven-segment path.

## Interface
Parameters:
- FILTER_LEN, 4: consecutive equal synchronised samples required to accept a `ps2_kbclk` level change (≥1).
- TIMEOUT_CYCLES, 50000: `computerClk` cycles without a falling edge before an in-progress frame is abandoned.
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2.

Ports (one clock; reset is synchronous and active-high):
- computerClk  in  1  system clock; every register is clocked on its rising edge.
- rst  in  1  synchronous active-high reset.
- ps2_kbclk  in  1  keyboard clock, asynchronous.
- ps2_kbdat  in  1  keyboard data, asynchronous.
- evt_valid  out  1  FIFO head is valid.
- evt_ready  in  1  consumer accepts the head.
- evt_code  out  8  scan-code byte of the head.
- evt_ext  out  1  head was preceded by E0.
- evt_brk  out  1  head was preceded by F0 (key release).
- evt_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- hexo  out  16  display word.
- err_parity  out  1  one-cycle pulse on parity failure.
- err_frame  out  1  one-cycle pulse on bad stop bit or timeout.
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- Input path:
  - Each line passes through a 2-flop synchroniser.
  - The filtered clock (reset value 1) flips only after FILTER_LEN consecutive samples that differ from its current value.
  - A 1→0 transition of the filtered clock produces `strobe`. The synchronised data bit is sampled in the same cycle.
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: strobe with data=0 → DATA, bit counter=0. Strobe with data=1 is ignored.
  - DATA: shift in LSB-first. After the 8th bit → PARITY.
  - PARITY: capture the bit → STOP.
  - STOP: if data=1 and XOR(8 data bits, parity)=1, emit `byte_ok`. If the parity check fails, pulse `err_parity`. If data=0, pulse `err_frame` (parity is not reported in that case). Always return to IDLE.
  - Timeout: in any non-IDLE state, a counter reaches TIMEOUT_CYCLES with no strobe → pulse `err_frame`, go to IDLE, discard partial data. The counter clears on every strobe and in IDLE.
- Event assembler:
  - On `byte_ok`, byte E0 sets `ext_pend` and byte F0 sets `brk_pend`.
  - Any other byte pushes {ext_pend, brk_pend, byte} and then clears both pending flags.
  - `err_parity` and `err_frame` clear both pending flags.
- `hexo`:
  - Updated on every push, including a push that is dropped:
    - bits [15:8] = F0 if brk, else E0 if ext, else 00;
    - bits [7:0] = code.
  - On `err_parity`, `hexo` is set to FFFF.
- FIFO:
  - Show-ahead: `evt_*` reflect the head while `evt_valid`=1. Their values are don't-care otherwise.
  - Pop when `evt_valid && evt_ready`.
  - Push when not full, or when full with a pop in the same cycle.
  - A push while full with no pop is dropped and pulses `overflow`.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset values: FSM=IDLE, counters=0, pending flags=0, FIFO empty, `evt_valid`=0, `evt_count`=0, `hexo`=0000, all error pulses=0, filtered clock=1, synchronisers=1.

## Timing
- Filter latency: a line change is seen as `strobe` 2+FILTER_LEN cycles after it is applied.
- Stop-bit strobe at cycle T:
  - `byte_ok` and error pulses are registered high in T+1 only.
  - The FIFO write and the `hexo` update occur at the T+1 edge.
  - `evt_valid` is high from T+2.
- Pop takes effect on the clock edge. The next head, or `evt_valid`=0, appears the following cycle.
- `rst` asserted mid-frame abandons the frame at the next edge without any error pulse.

## Structure
- Package `ps2_pkg`:
  - frame-state enum;
  - constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
  - packed struct `ps2_evt_t` {ext, brk, code[7:0]} (10 bits), shared with downstream consumers.
- One sub-module, `ps2_evt_fifo`: synchronous FIFO parameterised by DEPTH, element type `ps2_evt_t`. It provides full/empty, count and the simultaneous push/pop rule.
- Synchroniser, filter, FSM and assembler stay in the top module.

## Test plan
- Frame 1C with correct parity (0) → one event {0,0,1C}, `hexo`=001C, `evt_valid` at stop strobe T+2.
- Frames E0, F0, 75 → single event {1,1,75}, `hexo`=F075. Frames E0 then 75 → {1,0,75}, `hexo`=E075.
- Frame 1C with parity bit 1 → `err_parity` pulse, `hexo`=FFFF, no event. Next good 32 → {0,0,32} with no stale prefix.
- 5 data bits then silence for TIMEOUT_CYCLES → `err_frame` pulse, FSM=IDLE. Following good frame 1C is decoded correctly.
- `evt_ready`=0 with FIFO_DEPTH+1 events → `evt_count`=FIFO_DEPTH, one `overflow` pulse, head still first event. With the FIFO full, push and pop in the same cycle → count unchanged, no overflow.
- Glitches on `ps2_kbclk` shorter than FILTER_LEN cycles mid-frame → no extra strobes, byte decoded correctly.
- `rst` pulse mid-frame → clean recovery, no error pulse.
